// File: rtl/dpu_instr_issuer_if.sv
// Command handshake and DPU instruction bus for the instruction issuer.
// The issuer takes the master view: it consumes commands and drives instr_en/instr/activate.
interface dpu_instr_issuer_if #(
   parameter int PAYLOAD_W = 27,
   parameter int OPT_W     = 2,
   parameter int MODE_W    = 6,
   parameter int IMM_W     = 8,
   parameter int DLY_W     = 9,
   parameter int ACT_W     = 4
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_is_fsm;
   logic [OPT_W-1:0]     cmd_option;
   logic [MODE_W-1:0]    cmd_mode;
   logic [IMM_W-1:0]     cmd_immediate;
   logic [DLY_W-1:0]     cmd_delays;
   logic                 instr_en;
   logic [PAYLOAD_W-1:0] instr;
   logic [ACT_W-1:0]     activate;

   modport master (
      input  cmd_valid, cmd_is_fsm, cmd_option, cmd_mode, cmd_immediate, cmd_delays,
      output cmd_ready, instr_en, instr, activate
   );

   modport slave (
      output cmd_valid, cmd_is_fsm, cmd_option, cmd_mode, cmd_immediate, cmd_delays,
      input  cmd_ready, instr_en, instr, activate
   );
endinterface

// File: rtl/dpu_instr_issuer.sv
// Packs DPU/FSM config commands into 27-bit payloads, queues them, issues one per cycle,
// and on start drains the queue, leaves one idle cycle, then strobes activate.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | pops freely; start moves to S_DRAIN
//   S_DRAIN | pops until the queue is empty and nothing is arriving
//   S_GAP   | one quiet cycle, no pop, instr_en low
//   S_ACT   | activate = ACTIVATE_MASK, done pulse, no pop
module dpu_instr_issuer #(
   parameter int         INSTRUCTION_PAYLOAD_WIDTH = 27,
   parameter int         DPU_MODE_WIDTH            = 6,
   parameter int         DPU_IMMEDIATE_WIDTH       = 8,
   parameter int         FSM_MAX_STATES            = 4,
   parameter int         FSM_DELAY_WIDTH           = 3,
   parameter int         QUEUE_DEPTH               = 4,
   parameter logic [3:0] ACTIVATE_MASK             = 4'b0001
) (
   input  logic                               clk,
   input  logic                               rst,
   dpu_instr_issuer_if.master                 bus,
   input  logic                               start,
   input  logic                               issue_en,
   output logic                               busy,
   output logic                               done,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count
);

   localparam int PW      = INSTRUCTION_PAYLOAD_WIDTH;
   localparam int OPT_W   = $clog2(FSM_MAX_STATES);
   localparam int PTR_W   = $clog2(QUEUE_DEPTH);
   localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
   localparam int DLY_W   = FSM_DELAY_WIDTH;
   localparam int DPU_PAD = PW - 3 - OPT_W - DPU_MODE_WIDTH - DPU_IMMEDIATE_WIDTH;
   localparam int FSM_PAD = PW - 3 - 3 * DLY_W;

   localparam logic [2:0]       OP_DPU   = 3'd3;
   localparam logic [2:0]       OP_FSM   = 3'd2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_GAP,
      S_ACT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PW-1:0]    mem [QUEUE_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PW-1:0]    payload_in;
   logic             push;
   logic             pop;
   logic             pop_allowed;

   // Packing happens at enqueue, so the queue only ever holds finished payloads.
   always_comb begin
      payload_in = '0;
      if (bus.cmd_is_fsm) begin
         payload_in = {OP_FSM,
                       bus.cmd_delays[DLY_W-1:0],
                       bus.cmd_delays[2*DLY_W-1:DLY_W],
                       bus.cmd_delays[3*DLY_W-1:2*DLY_W],
                       {FSM_PAD{1'b0}}};
      end else begin
         payload_in = {OP_DPU, bus.cmd_option, bus.cmd_mode, bus.cmd_immediate,
                       {DPU_PAD{1'b0}}};
      end
   end

   // A full queue refuses the command even if a pop frees a slot on the same edge.
   assign bus.cmd_ready = (count != FULL_CNT);
   assign push          = bus.cmd_valid && bus.cmd_ready;
   assign pop_allowed   = (state == S_IDLE) || (state == S_DRAIN);
   assign pop           = (count != '0) && issue_en && pop_allowed;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= payload_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // instr holds the last issued payload while instr_en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.instr_en <= 1'b0;
         bus.instr    <= '0;
      end else begin
         bus.instr_en <= pop;
         if (pop) begin
            bus.instr <= mem[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bus.activate = '0;
      done         = 1'b0;
      busy         = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // A command landing on the empty edge must still be drained before the gap.
            if ((count == '0) && !push) begin
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            state_nxt = S_ACT;
         end
         S_ACT: begin
            bus.activate = ACTIVATE_MASK;
            done         = 1'b1;
            state_nxt    = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   a_count_range: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);

   a_quiet_before_act: assert property (@(posedge clk) disable iff (rst)
      (state == S_ACT) |-> (!bus.instr_en && !$past(bus.instr_en)));

endmodule

// File: tb/tb_dpu_instr_issuer.sv
// Bench for dpu_instr_issuer: directed scenarios plus random traffic against a queue-based model.
module tb_dpu_instr_issuer;

   localparam logic [3:0] MASK  = 4'b0001;
   localparam int         DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       issue_en;
   logic       busy;
   logic       done;
   logic [2:0] count;

   always #5 clk = ~clk;

   dpu_instr_issuer_if bus ();

   dpu_instr_issuer dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .start    (start),
      .issue_en (issue_en),
      .busy     (busy),
      .done     (done),
      .count    (count)
   );

   int total = 0;
   int bad   = 0;

   // Model: payloads waiting, whether a drain is in progress, cycles left until activate ends.
   logic [26:0] mq [$];
   bit          m_drain;
   int          m_act;
   bit          m_en;
   logic [26:0] m_instr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [26:0] pack(input logic is_fsm, input logic [1:0] opt,
                                        input logic [5:0] mode, input logic [7:0] imm,
                                        input logic [8:0] dly);
      int r;
      int d;
      d = int'(dly);
      if (is_fsm)
         r = 2 * (1 << 24) + (d % 8) * (1 << 21) + ((d / 8) % 8) * (1 << 18) + (d / 64) * (1 << 15);
      else
         r = 3 * (1 << 24) + int'(opt) * (1 << 22) + int'(mode) * (1 << 16) + int'(imm) * (1 << 8);
      return 27'(r);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_drain = 1'b0;
      m_act   = 0;
      m_en    = 1'b0;
      m_instr = '0;
   endtask

   // One clock: predict from the inputs now applied, advance, then compare every output.
   task automatic cycle();
      bit          ready;
      bit          push;
      bit          pop;
      int          pre;
      logic [26:0] pl;
      pre   = mq.size();
      ready = (pre != DEPTH);
      check("cmd_ready", 32'(bus.cmd_ready), 32'(ready));
      push = (bus.cmd_valid === 1'b1) && ready;
      pl   = pack(bus.cmd_is_fsm, bus.cmd_option, bus.cmd_mode, bus.cmd_immediate, bus.cmd_delays);
      pop  = (pre > 0) && (issue_en === 1'b1) && (m_act == 0);
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         m_en = pop;
         if (pop) m_instr = mq.pop_front();
         if (m_act > 0) begin
            m_act--;
         end else if (m_drain) begin
            if (pre == 0 && !push) begin
               m_drain = 1'b0;
               m_act   = 2;
            end
         end else if (start) begin
            m_drain = 1'b1;
         end
         if (push) mq.push_back(pl);
      end
      check("instr_en", 32'(bus.instr_en), 32'(m_en));
      check("instr", 32'(bus.instr), 32'(m_instr));
      check("count", 32'(count), 32'(mq.size()));
      check("activate", 32'(bus.activate), (m_act == 1) ? 32'(MASK) : 32'd0);
      check("done", 32'(done), 32'(m_act == 1));
      check("busy", 32'(busy), 32'(m_drain || (m_act > 0)));
   endtask

   task automatic dpu_cmd(input logic [1:0] o, input logic [5:0] m, input logic [7:0] i);
      bus.cmd_valid     = 1'b1;
      bus.cmd_is_fsm    = 1'b0;
      bus.cmd_option    = o;
      bus.cmd_mode      = m;
      bus.cmd_immediate = i;
      bus.cmd_delays    = 9'($urandom);
   endtask

   task automatic fsm_cmd(input int d0, input int d1, input int d2);
      bus.cmd_valid     = 1'b1;
      bus.cmd_is_fsm    = 1'b1;
      bus.cmd_option    = 2'($urandom);
      bus.cmd_mode      = 6'($urandom);
      bus.cmd_immediate = 8'($urandom);
      bus.cmd_delays    = 9'(d0 + d1 * 8 + d2 * 64);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit exp_en  [8];
      bit exp_act [8];
      bit exp_busy[8];

      rst               = 1'b1;
      start             = 1'b0;
      issue_en          = 1'b0;
      bus.cmd_valid     = 1'b0;
      bus.cmd_is_fsm    = 1'b0;
      bus.cmd_option    = '0;
      bus.cmd_mode      = '0;
      bus.cmd_immediate = '0;
      bus.cmd_delays    = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      cycle();
      check("rst_instr_en", 32'(bus.instr_en), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_activate", 32'(bus.activate), 32'd0);
      rst      = 1'b0;
      issue_en = 1'b1;

      // Single DPU command: issued on the second edge after acceptance.
      dpu_cmd(2'd1, 6'd10, 8'h05);
      cycle();
      check("t1_not_yet", 32'(bus.instr_en), 32'd0);
      bus.cmd_valid = 1'b0;
      cycle();
      check("t1_en", 32'(bus.instr_en), 32'd1);
      check("t1_instr", 32'(bus.instr), 32'h34A0500);
      cycle();
      check("t1_single", 32'(bus.instr_en), 32'd0);

      // FSM then DPU back to back.
      fsm_cmd(2, 3, 1);
      cycle();
      dpu_cmd(2'd0, 6'd1, 8'd0);
      cycle();
      bus.cmd_valid = 1'b0;
      check("t2_fsm_en", 32'(bus.instr_en), 32'd1);
      check("t2_fsm", 32'(bus.instr), 32'h24C8000);
      cycle();
      check("t2_dpu_en", 32'(bus.instr_en), 32'd1);
      check("t2_dpu", 32'(bus.instr), 32'h3010000);
      cycle();

      // Fill to full with issue stalled, then release.
      issue_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         dpu_cmd(2'(i), 6'(i + 1), 8'(i + 2));
         cycle();
      end
      check("t3_full_count", 32'(count), 32'd4);
      check("t3_full_ready", 32'(bus.cmd_ready), 32'd0);
      bus.cmd_valid = 1'b0;
      issue_en      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t3_en", 32'(bus.instr_en), 32'd1);
         check("t3_order", 32'(bus.instr), 32'(pack(1'b0, 2'(i), 6'(i + 1), 8'(i + 2), 9'd0)));
         if (i == 0) check("t3_ready_back", 32'(bus.cmd_ready), 32'd1);
      end
      cycle();
      check("t3_idle", 32'(bus.instr_en), 32'd0);

      // Three queued, then start; a second start during the drain must be ignored.
      issue_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fsm_cmd(i, i + 1, 7 - i);
         cycle();
      end
      bus.cmd_valid = 1'b0;
      issue_en      = 1'b1;
      exp_en   = '{1, 1, 1, 0, 0, 0, 0, 0};
      exp_act  = '{0, 0, 0, 0, 1, 0, 0, 0};
      exp_busy = '{1, 1, 1, 1, 1, 0, 0, 0};
      for (int k = 0; k < 8; k++) begin
         start = (k == 0 || k == 2);
         cycle();
         check("t4_en", 32'(bus.instr_en), 32'(exp_en[k]));
         check("t4_act", 32'(bus.activate), exp_act[k] ? 32'(MASK) : 32'd0);
         check("t4_done", 32'(done), 32'(exp_act[k]));
         check("t4_busy", 32'(busy), 32'(exp_busy[k]));
      end

      // Start with nothing queued.
      for (int k = 0; k < 5; k++) begin
         start = (k == 0);
         cycle();
         check("t5_act", 32'(bus.activate), (k == 2) ? 32'(MASK) : 32'd0);
         check("t5_en", 32'(bus.instr_en), 32'd0);
         check("t5_busy", 32'(busy), 32'(k < 3));
      end

      // Reset in the middle of a drain.
      issue_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dpu_cmd(2'(i + 1), 6'(7 * i), 8'(9 * i));
         cycle();
      end
      bus.cmd_valid = 1'b0;
      start         = 1'b1;
      cycle();
      start    = 1'b0;
      issue_en = 1'b1;
      cycle();
      check("t6_count2", 32'(count), 32'd2);
      issue_en = 1'b0;
      rst      = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_count", 32'(count), 32'd0);
      check("t6_en", 32'(bus.instr_en), 32'd0);
      check("t6_act", 32'(bus.activate), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      issue_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("t6_no_act", 32'(bus.activate), 32'd0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst               = ($urandom_range(0, 199) == 0);
         bus.cmd_valid     = ($urandom_range(0, 9) < 6);
         bus.cmd_is_fsm    = 1'($urandom);
         bus.cmd_option    = 2'($urandom);
         bus.cmd_mode      = 6'($urandom);
         bus.cmd_immediate = 8'($urandom);
         bus.cmd_delays    = 9'($urandom);
         issue_en          = ($urandom_range(0, 9) < 8);
         start             = ($urandom_range(0, 19) == 0);
         cycle();
      end
      rst           = 1'b0;
      bus.cmd_valid = 1'b0;
      start         = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dpu_instr_issuer.md
Name: dpu_instr_issuer

Overview:
- Instruction-side transmitter for a DPU resource slot. It is the initiator that drives the instr_en / instr / activate interface the DPU consumes.
- It accepts high-level DPU-config and FSM-config commands over a valid/ready handshake and packs each into the 27-bit DPU payload format.
- Packed payloads are buffered in a small FIFO and issued one per cycle.
- On a start request it drains the FIFO, inserts one idle cycle, then pulses activate.

Parameters:
- INSTRUCTION_PAYLOAD_WIDTH, 27, width of instr output
- DPU_MODE_WIDTH, 6, mode field width
- DPU_IMMEDIATE_WIDTH, 8, immediate field width
- FSM_MAX_STATES, 4, DPU FSM states; option field = $clog2(FSM_MAX_STATES) bits
- FSM_DELAY_WIDTH, 3, width of each FSM delay
- QUEUE_DEPTH, 4, FIFO entries (power of 2, ≥2)
- ACTIVATE_MASK, 4'b0001, value driven on activate during the activate cycle

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_is_fsm  in  1  0 = DPU config, 1 = FSM config
- cmd_option  in  2  DPU state slot (DPU cmd only)
- cmd_mode  in  6  DPU mode (DPU cmd only)
- cmd_immediate  in  8  DPU immediate (DPU cmd only)
- cmd_delays  in  9  delay_0 = [2:0], delay_1 = [5:3], delay_2 = [8:6] (FSM cmd only)
- start  in  1  request drain + activate
- issue_en  in  1  issue gate; 0 stalls popping
- instr_en  out  1  instruction valid to resource
- instr  out  27  packed payload
- activate  out  4  activate strobe
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, coincident with activate
- count  out  3  FIFO occupancy, 0..QUEUE_DEPTH

Behaviour:
- Clock and reset: single clock domain (clk); reset rst is synchronous and active-high.
- Reset values: instr_en=0, instr=0, activate=0, busy=0, done=0, count=0, cmd_ready=1, state=IDLE. Reset mid-operation discards FIFO contents and aborts any pending drain/activate next cycle.
- DPU packing (opcode 3): [26:24]=3'd3, [23:22]=option, [21:16]=mode, [15:8]=immediate, [7:0]=0.
- FSM packing (opcode 2): [26:24]=3'd2, [23:21]=delay_0, [20:18]=delay_1, [17:15]=delay_2, [14:0]=0.
- Packing happens at enqueue; the FIFO stores 27-bit payloads. Fields wider than their slot cannot occur; unused inputs are ignored.
- cmd_ready = (count != QUEUE_DEPTH), from registered count.
  - When full, no enqueue occurs even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
- Pop condition: count>0 && issue_en && state ∈ {IDLE, DRAIN}.
- instr_en and instr are registered: on a pop edge they load 1/head; otherwise instr_en<=0 and instr holds its last value.
- Latency: command accepted at edge t → instr_en high in the cycle after edge t+1, assuming empty FIFO and issue_en=1. Issue rate is one per cycle.
- State machine:
  - IDLE: pops freely. start=1 → DRAIN.
  - DRAIN: pops. count==0 (registered) → GAP. Commands accepted during DRAIN are also drained before exit.
  - GAP: one cycle; no pop; instr_en=0. → ACT.
  - ACT: activate=ACTIVATE_MASK, done=1 for this one cycle; no pop. → IDLE.
- activate and done are 0 in all other states.
- start outside IDLE is ignored (not queued).
- start with an empty FIFO: DRAIN, GAP, ACT on the three cycles after the start cycle.
- issue_en=0 during DRAIN: stays in DRAIN with count held until issue_en returns.
- Guarantee: at least one cycle with instr_en=0 separates the last issued instruction from the activate cycle.
- Commands may still be enqueued during GAP and ACT; they issue after returning to IDLE.

Test Plan:
- DPU cmd option=1, mode=10, imm=0x05, issue_en=1 → exactly one instr_en cycle, 2 cycles after acceptance, with instr=0x34A0500.
- FSM cmd delays 0=2, 1=3, 2=1 → instr=0x24C8000. Then a DPU cmd option=0, mode=1, imm=0 → instr=0x3010000 on the next consecutive cycle.
- issue_en=0, push 5 cmds → cmd_ready drops after 4 accepted, count=4. Raise issue_en → 4 consecutive instr_en cycles in order, cmd_ready returns the cycle after the first pop.
- Queue 3 cmds, assert start with issue_en=1 → 3 instr_en cycles, then 1 idle cycle, then activate=4'b0001 with done=1 for exactly one cycle; busy high from the cycle after start until the cycle after ACT. A start pulse during DRAIN is ignored.
- start with empty FIFO → activate=4'b0001 on the third cycle after start, with no instr_en.
- Assert rst during DRAIN with count=2 → next cycle count=0, instr_en=0, activate=0, busy=0; no activate ever follows.
